// File: rtl/mux4_pkg.sv
// ============================================================================
// Module   : mux4_pkg
// Brief    : Shared types and round-robin pick helper for the mux4 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // Scans ptr, ptr+1, ... mod 4; descending loop lets the closest candidate win.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [N_REQ-1:0] mask,
                                      input sel_t             ptr);
        pick_t p;
        sel_t  cand;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + sel_t'(i);
            if (req[cand] && !mask[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4.sv
// ============================================================================
// Module   : mux4
// Brief    : Shared 4-input DATA_W-wide combinational data multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4
    import mux4_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  sel_t              sel,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter sharing a mux4 datapath, valid/ready output.
//            Optional burst lock via `define MUX4_RR_ARBITER_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux4_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MUX4_RR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]  lock,
`endif
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [N_REQ-1:0]  ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output sel_t              out_sel
);

    arb_state_t        r_state;
    sel_t              r_ptr;
    sel_t              r_sel;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    logic              w_hs;
    logic              w_lock;
    sel_t              w_pick_ptr;
    logic [N_REQ-1:0]  w_mask;
    pick_t             w_pick;
    logic [DATA_W-1:0] w_mux_data;

    assign w_hs = r_valid & out_ready;

`ifdef MUX4_RR_ARBITER_LOCK_EN
    assign w_lock = lock[r_sel];
`else
    assign w_lock = 1'b0;
`endif

    // In HOLD the pick only matters on a handshake; the acked requester still
    // has req high, so it is masked unless its lock keeps the burst going.
    always_comb begin
        w_pick_ptr = r_ptr;
        w_mask     = '0;
        if (r_state == HOLD) begin
            w_pick_ptr = w_lock ? r_sel : r_sel + 2'd1;
            if (!w_lock) begin
                w_mask[r_sel] = 1'b1;
            end
        end
    end

    assign w_pick = rr_pick(req, w_mask, w_pick_ptr);

    mux4 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (w_pick.idx),
        .y   (w_mux_data)
    );

    always_comb begin
        ack = '0;
        if (w_hs) begin
            ack[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_sel   <= w_pick.idx;
                        r_data  <= w_mux_data;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (!w_lock) begin
                            r_ptr <= r_sel + 2'd1;
                        end
                        if (w_pick.found) begin
                            r_sel  <= w_pick.idx;
                            r_data <= w_mux_data;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Scoreboard bench for mux4_rr_arbiter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    localparam int DATA_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req = '0;
    logic [3:0]        lock = '0;
    logic [DATA_W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [3:0]        ack;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is {sel, data} of a word expected to be handed off.
    logic [3:0] exp_q[$];

    mux4_rr_arbiter #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX4_RR_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [DATA_W-1:0] data);
        exp_q.push_back({sel, data});
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_sel",   32'(out_sel),   32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        req       = '0;
        lock      = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops on every handshake, otherwise ack must stay low.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] one;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {30'd0, out_sel}, 32'hFFFF_FFFF);
                end else begin
                    e   = exp_q.pop_front();
                    one = 4'b0001 << e[3:2];
                    check("mon_sel",  32'(out_sel),  32'(e[3:2]));
                    check("mon_data", 32'(out_data), 32'(e[1:0]));
                    check("mon_ack",  32'(ack),      32'(one));
                end
            end else begin
                check("mon_ack_idle", 32'(ack), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single request from requester 2.
        req = 4'b0100; in2 = 2'b11; out_ready = 1'b1;
        push(2'd2, 2'b11);
        tick();
        tick();
        req = '0;
        @(negedge clk);
        check("single_valid_drop", 32'(out_valid), 32'd0);
        tick();

        // All requesting: rotating grants from pointer 0.
        do_reset();
        in0 = 2'd0; in1 = 2'd1; in2 = 2'd2; in3 = 2'd3;
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(2'(i % 4), 2'(i % 4));
        repeat (6) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("rr_next_pending_sel", 32'(out_sel), 32'd1);

        // Backpressure; the pending word above is dropped by reset.
        do_reset();
        in0 = 2'b10; in3 = 2'b01; req = 4'b1001; out_ready = 1'b0;
        push(2'd0, 2'b10);
        push(2'd3, 2'b01);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sel",   32'(out_sel),   32'd0);
            check("bp_data",  32'(out_data),  32'(2'b10));
            tick();
        end
        out_ready = 1'b1;
        tick();
        req = 4'b1000;
        tick();
        req = '0;
        @(negedge clk);
        check("bp_idle", 32'(out_valid), 32'd0);
        tick();

        // Sole requester held: acked word is masked, giving a one-cycle gap.
        do_reset();
        in1 = 2'b01; req = 4'b0010; out_ready = 1'b1;
        push(2'd1, 2'b01);
        push(2'd1, 2'b01);
        tick();
        tick();
        @(negedge clk);
        check("sole_gap", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("sole_regrant", 32'(out_valid), 32'd1);
        tick();
        req = '0;
        @(negedge clk);
        check("sole_end", 32'(out_valid), 32'd0);
        tick();

`ifdef MUX4_RR_ARBITER_LOCK_EN
        // Locked burst on requester 0, then round-robin resumes at 1.
        do_reset();
        in0 = 2'd2; in1 = 2'd1; req = 4'b0011; lock = 4'b0001; out_ready = 1'b1;
        repeat (3) push(2'd0, 2'd2);
        push(2'd1, 2'd1);
        tick();
        tick();
        tick();
        lock = '0;
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        @(negedge clk);
        check("lock_end", 32'(out_valid), 32'd0);
        tick();
`endif

        check("final_sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
